// File: rtl/rv_lsu.sv
// rv_lsu -- load/store unit between the core's EXEC/MEM stages and the data
// memory or bus fabric.
//
// The core side is a valid/ready request port with a single-cycle response
// pulse (no back-pressure). The memory side is request/grant with a separate
// read-data valid, and it may insert any number of wait states. The unit
// handles byte-lane steering for stores, and sign/zero extension for loads.
// It flags misaligned accesses and illegal size codes, and it aborts an
// access that stalls for too long.
//
// Parameters:
//   ADDR_W   byte-address width on both sides
//   TIMEOUT  max cycles spent in REQ+WAIT before an error response (0 = off)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    core presents an access
//   req_ready    unit accepts the access (high only in IDLE)
//   req_we       1 = store, 0 = load
//   req_funct3   RV32I size/sign code (B, H, W, BU, HU)
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   resp_valid   one-cycle completion pulse
//   resp_rdata   extended load data (0 for stores and errors)
//   resp_err     00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   mem_req      memory request, held until mem_gnt
//   mem_addr     word-aligned address
//   mem_we       byte write enables (0000 for loads)
//   mem_wdata    lane-steered store data
//   mem_gnt      memory accepts the request this cycle
//   mem_rvalid   load data valid on mem_rdata
//   mem_rdata    word read data

module rv_lsu #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_MISALGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL = 2'b11;

   // The counter only ever needs to hold TIMEOUT-1.
   localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          off_q, off_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]          mem_we_q, mem_we_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic [31:0]         resp_rdata_q, resp_rdata_d;
   logic [1:0]          resp_err_q, resp_err_d;

   logic                illegal;
   logic                misaligned;
   logic                timeout_hit;
   logic [3:0]          steer_we;
   logic [31:0]         steer_wdata;

   // Pick the addressed byte or half out of the read word and extend it.
   // funct3[2] set means zero-extend (BU/HU); W passes straight through.
   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3[1:0])
         2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
         2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Request classification on the raw core inputs, used only at acceptance.
   // Stores have no unsigned variants, so any funct3[2] store is illegal.
   always_comb begin
      if (req_we) begin
         illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      end else begin
         illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      end
      misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
   end

   // Store lane steering: replicate narrow data across the word so the
   // memory only has to honour the byte enables.
   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            steer_wdata = {4{req_wdata[7:0]}};
            steer_we    = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            steer_wdata = {2{req_wdata[15:0]}};
            steer_we    = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            steer_wdata = req_wdata;
            steer_we    = 4'b1111;
         end
      endcase
   end

   // Next-state logic. A completing event always takes precedence over the
   // timeout in the same cycle; a grant alone does not complete a load.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = mem_we_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = ERR_OK;
      timeout_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               cnt_d    = '0;
               if (illegal) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = ERR_ILLEGAL;
               end else if (misaligned) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = ERR_MISALGN;
               end else begin
                  state_d     = S_REQ;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                  mem_we_d    = req_we ? steer_we : 4'b0000;
                  mem_wdata_d = req_we ? steer_wdata : 32'h0;
               end
            end
         end

         S_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_gnt && (we_q || mem_rvalid)) begin
               state_d      = S_RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? 32'h0 : load_extract(funct3_q, off_q, mem_rdata);
            end else if (timeout_hit) begin
               state_d      = S_RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = ERR_TIMEOUT;
            end else if (mem_gnt) begin
               state_d   = S_WAIT;
               mem_req_d = 1'b0;
            end
         end

         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_rvalid) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extract(funct3_q, off_q, mem_rdata);
            end else if (timeout_hit) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = ERR_TIMEOUT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // All state and all outputs except req_ready are registered here; reset
   // abandons any in-flight memory transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 4'b0000;
         mem_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= ERR_OK;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
